scm_sent_ctrl: RTL
==================

// Module: scm_sent_ctrl
// PURPOSE
//  Sequencer for the SCM capture/sent window. Sits on the 134b config chain upstream of scm.
//  Decodes register writes/reads addressed to itself; passes all other words through.
//  Issues gac2scm_sent_start/end pulses around a window bounded by packet count or cycle timeout.
//  Supplies the free-running um2scm_timestamp.
// PARAMETERS
//  MODULE_ID  8'd7   value matched against cfg word [103:96]
//  CNT_W      32     width of packet counter and window timer
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    synchronous active-high reset
//  cin_ctrl_data       in   134  config word from DMA side
//  cin_ctrl_data_wr    in   1    config word valid
//  cout_ctrl_ready     out  1    this block can accept a word
//  cout_ctrl_data      out  134  config word to scm chain
//  cout_ctrl_data_wr   out  1    output word valid
//  cin_ctrl_ready      in   1    downstream can accept a word
//  scm_md_wr           in   1    metadata write strobe into scm; one pulse = one packet
//  gac2scm_sent_start  out  1    one-cycle window-open pulse
//  gac2scm_sent_end    out  1    one-cycle window-close pulse
//  um2scm_timestamp    out  32   free-running cycle counter
//  ctrl_busy           out  1    FSM not in IDLE
// BEHAVIOUR
//  Cfg word fields: [133:128] flit flag, [127] valid, [126:124] op (001 wr, 010 rd, 011 rd-resp),
//   [111:104] src id, [103:96] dst id, [95:64] addr, [63:32] rsvd, [31:0] data.
//  Local hit: wr=1, [127]=1, [103:96]==MODULE_ID, addr[31:28]==4'h8.
//   Non-hit words are forwarded unchanged.
//  Regs:
//   0x80000000 CTRL, bit0 arm (self-clearing), bit1 abort (self-clearing).
//   0x80000001 PKT_NUM.
//   0x80000002 PERIOD, timeout in cycles; 0 = no timeout.
//   0x80000003 STATUS, RO: {state[1:0], 14'b0, sent_cnt[15:0]}.
//  Local write: register updates on the accept cycle; word is still forwarded unchanged.
//  Local read: forwarded with op=011 and [31:0]=register value.
//  Unmapped local addr: writes ignored; reads return 0.
//  Config path:
//   1-stage register; cout_ctrl_ready = cin_ctrl_ready | ~out_valid.
//   Accept = cin_ctrl_data_wr & cout_ctrl_ready; output holds while out_valid & ~cin_ctrl_ready.
//   Latency 1 cycle; back-to-back words at full rate when cin_ctrl_ready=1.
//  FSM IDLE -> START -> RUN -> END -> IDLE:
//   IDLE:  arm write -> START. Arm while not IDLE is ignored.
//   START: sent_start=1 for exactly 1 cycle; clear sent_cnt and timer -> RUN.
//   RUN:   sent_cnt += scm_md_wr; timer++ (saturates at max).
//          Go to END when any of:
//           - sent_cnt+scm_md_wr >= PKT_NUM
//           - PERIOD!=0 and timer+1 == PERIOD
//           - abort write
//          PKT_NUM==0: RUN lasts exactly 1 cycle.
//   END:   sent_end=1 for 1 cycle -> IDLE. sent_cnt is held for STATUS until the next START.
//  Simultaneous events in RUN:
//   - Count-hit and timeout in the same cycle give a single END.
//   - An md_wr in the terminating cycle is counted.
//  PKT_NUM/PERIOD writes during RUN take effect the next cycle.
//  Timestamp: +1 every cycle, wraps 0xFFFFFFFF -> 0; 0 on reset.
//  Reset, including mid-window: all outputs 0, state IDLE, regs 0, pending cfg word dropped.
//   No sent_end is issued for an aborted window.
// STRUCTURE
//  Shared pkg scm_pkg: cfg field offsets, op codes, register addresses, FSM state encodings.
//  One sub-module: scm_cfg_slave (decode, pipeline register, read-data mux).
//  FSM and counters stay in the top.
// TESTING
//  1. Reset, then idle 5 cyc:
//     -> all outputs 0, cout_ctrl_ready=1, timestamp=4 at the 5th cycle after reset release.
//  2. Non-hit word (dst 8'd5, addr 0x70000003):
//     -> same 134b value on cout 1 cycle later; no register change.
//  3. Write PKT_NUM=3, PERIOD=0, then CTRL=1:
//     -> sent_start 1 cycle after the arm accept; after 3 scm_md_wr pulses, sent_end 1 cycle after the 3rd.
//  4. PKT_NUM=10, PERIOD=20, no md_wr:
//     -> sent_end at the 21st cycle after sent_start; STATUS read returns cnt 0.
//  5. Hold cin_ctrl_ready=0 for 4 cycles with 2 words offered:
//     -> 1st word held stable, 2nd word stalled (cout_ctrl_ready=0); no loss or duplication.
//  6. Arm, then assert rst during RUN:
//     -> no sent_end, state IDLE; STATUS read returns 0.

Source files
------------

// File: rtl/scm_pkg.sv
// Shared definitions for the SCM config chain: word field positions, op codes,
// local register map and the sent-window sequencer state encoding.
package scm_pkg;

  localparam int CFG_W    = 134;
  localparam int VALID_B  = 127;
  localparam int OP_HI    = 126;
  localparam int OP_LO    = 124;
  localparam int DST_HI   = 103;
  localparam int DST_LO   = 96;
  localparam int ADDR_HI  = 95;
  localparam int ADDR_LO  = 64;
  localparam int DATA_HI  = 31;

  localparam logic [2:0] OP_WR   = 3'b001;
  localparam logic [2:0] OP_RD   = 3'b010;
  localparam logic [2:0] OP_RRSP = 3'b011;

  localparam logic [3:0]  LOCAL_PAGE = 4'h8;
  localparam logic [31:0] REG_BASE   = 32'h8000_0000;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PKT    = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_END   = 2'd3
  } state_t;

endpackage

// File: rtl/scm_cfg_slave.sv
// Config-chain slave: one-deep forwarding register with local-address decode,
// register write strobe and read-response substitution.
module scm_cfg_slave
  import scm_pkg::*;
#(
  parameter logic [7:0] MODULE_ID = 8'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] cin_ctrl_data,
  input  logic             cin_ctrl_data_wr,
  output logic             cout_ctrl_ready,
  output logic [CFG_W-1:0] cout_ctrl_data,
  output logic             cout_ctrl_data_wr,
  input  logic             cin_ctrl_ready,
  output logic             reg_we,
  output logic [1:0]       reg_sel,
  output logic [31:0]      reg_wdata,
  input  logic [31:0]      pkt_num_rd,
  input  logic [31:0]      period_rd,
  input  logic [31:0]      status_rd
);

  logic             vld_p1;
  logic [CFG_W-1:0] data_p1;
  logic             accept;
  logic             hit;
  logic             mapped;
  logic [2:0]       op;
  logic [31:0]      addr;
  logic [31:0]      rdata;
  logic [CFG_W-1:0] fwd;

  assign op        = cin_ctrl_data[OP_HI:OP_LO];
  assign addr      = cin_ctrl_data[ADDR_HI:ADDR_LO];
  assign hit       = cin_ctrl_data_wr & cin_ctrl_data[VALID_B]
                   & (cin_ctrl_data[DST_HI:DST_LO] == MODULE_ID)
                   & (addr[31:28] == LOCAL_PAGE);
  assign mapped    = (addr[31:2] == REG_BASE[31:2]);
  assign reg_sel   = addr[1:0];
  assign reg_wdata = cin_ctrl_data[DATA_HI:0];

  assign cout_ctrl_ready   = cin_ctrl_ready | ~vld_p1;
  assign accept            = cin_ctrl_data_wr & cout_ctrl_ready;
  assign reg_we            = accept & hit & mapped & (op == OP_WR);
  assign cout_ctrl_data    = data_p1;
  assign cout_ctrl_data_wr = vld_p1;

  // CTRL is write-only pulses, so it reads back as zero like unmapped space
  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (reg_sel)
        REG_PKT:    rdata = pkt_num_rd;
        REG_PERIOD: rdata = period_rd;
        REG_STATUS: rdata = status_rd;
        default:    rdata = '0;
      endcase
    end
    fwd = cin_ctrl_data;
    if (hit && op == OP_RD) begin
      fwd[OP_HI:OP_LO] = OP_RRSP;
      fwd[DATA_HI:0]   = rdata;
    end
  end

  // stage p1: output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= fwd;
    end else if (cin_ctrl_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/scm_sent_ctrl.sv
// Sent-window sequencer: opens/closes the SCM capture window on packet count,
// cycle timeout or abort, and provides the free-running timestamp.
module scm_sent_ctrl
  import scm_pkg::*;
#(
  parameter logic [7:0] MODULE_ID = 8'd7,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] cin_ctrl_data,
  input  logic             cin_ctrl_data_wr,
  output logic             cout_ctrl_ready,
  output logic [CFG_W-1:0] cout_ctrl_data,
  output logic             cout_ctrl_data_wr,
  input  logic             cin_ctrl_ready,
  input  logic             scm_md_wr,
  output logic             gac2scm_sent_start,
  output logic             gac2scm_sent_end,
  output logic [31:0]      um2scm_timestamp,
  output logic             ctrl_busy
);

  logic             reg_we;
  logic [1:0]       reg_sel;
  logic [31:0]      reg_wdata;
  logic [CNT_W-1:0] pkt_num;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] sent_cnt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W:0]   cnt_next;
  logic [CNT_W:0]   tmr_next;
  logic [31:0]      status;
  logic             arm;
  logic             abort;
  logic             cnt_hit;
  logic             tmo;
  state_t           state;

  scm_cfg_slave #(.MODULE_ID(MODULE_ID)) u_slave (
    .clk               (clk),
    .rst               (rst),
    .cin_ctrl_data     (cin_ctrl_data),
    .cin_ctrl_data_wr  (cin_ctrl_data_wr),
    .cout_ctrl_ready   (cout_ctrl_ready),
    .cout_ctrl_data    (cout_ctrl_data),
    .cout_ctrl_data_wr (cout_ctrl_data_wr),
    .cin_ctrl_ready    (cin_ctrl_ready),
    .reg_we            (reg_we),
    .reg_sel           (reg_sel),
    .reg_wdata         (reg_wdata),
    .pkt_num_rd        (32'(pkt_num)),
    .period_rd         (32'(period)),
    .status_rd         (status)
  );

  assign status    = {state, 14'b0, sent_cnt[15:0]};
  assign ctrl_busy = (state != ST_IDLE);
  assign arm       = reg_we & (reg_sel == REG_CTRL) & reg_wdata[0];
  assign abort     = reg_we & (reg_sel == REG_CTRL) & reg_wdata[1];

  // the strobe arriving in the terminating cycle still counts toward the hit
  assign cnt_next = {1'b0, sent_cnt} + (CNT_W+1)'(scm_md_wr);
  assign tmr_next = {1'b0, timer} + 1'b1;
  assign cnt_hit  = (cnt_next >= {1'b0, pkt_num});
  assign tmo      = (period != '0) && (tmr_next == {1'b0, period});

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_num <= '0;
      period  <= '0;
    end else if (reg_we) begin
      if (reg_sel == REG_PKT)    pkt_num <= CNT_W'(reg_wdata);
      if (reg_sel == REG_PERIOD) period  <= CNT_W'(reg_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) um2scm_timestamp <= '0;
    else     um2scm_timestamp <= um2scm_timestamp + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      gac2scm_sent_start <= 1'b0;
      gac2scm_sent_end   <= 1'b0;
      sent_cnt           <= '0;
      timer              <= '0;
    end else begin
      gac2scm_sent_start <= 1'b0;
      gac2scm_sent_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state              <= ST_START;
            gac2scm_sent_start <= 1'b1;
          end
        end
        ST_START: begin
          sent_cnt <= '0;
          timer    <= '0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          sent_cnt <= cnt_next[CNT_W-1:0];
          if (timer != '1) timer <= tmr_next[CNT_W-1:0];
          if (cnt_hit || tmo || abort) begin
            state            <= ST_END;
            gac2scm_sent_end <= 1'b1;
          end
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
